// File: rtl/prog_loader.sv
// Boot-time program loader: packs a length-prefixed byte stream into 32-bit words,
// writes them to program memory at consecutive addresses, then releases the core.
module prog_loader #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        load_req,
    output logic        pm_write,
    output logic [7:0]  pm_addr,
    output logic [31:0] pm_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    localparam int unsigned WCNT_W = 9;

    typedef enum logic [2:0] {
        S_WAIT_LEN = 3'd0,
        S_RECV     = 3'd1,
        S_WRITE    = 3'd2,
        S_RUN      = 3'd3,
        S_ERR      = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WCNT_W-1:0] len_q;
    logic [WCNT_W-1:0] word_cnt_q;
    logic [1:0]        byte_cnt_q;
    logic [CNT_W-1:0]  tmo_q;
    logic              xfer;
    logic              tmo_en;
    logic              tmo_hit;
    logic              word_last;

    assign xfer      = rx_valid & rx_ready;
    assign tmo_en    = (TIMEOUT_CYC != 0);
    assign tmo_hit   = tmo_en && (tmo_q == CNT_W'(TIMEOUT_CYC));
    assign word_last = (word_cnt_q + WCNT_W'(1)) == len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_LEN: if (xfer) state_d = S_RECV;
            S_RECV: begin
                if (xfer && (byte_cnt_q == 2'd3)) begin
                    state_d = S_WRITE;
                end else if (!xfer && tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WRITE:    state_d = word_last ? S_RUN : S_RECV;
            S_RUN:      if (load_req) state_d = S_WAIT_LEN;
            S_ERR:      if (load_req) state_d = S_WAIT_LEN;
            default:    state_d = S_WAIT_LEN;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        pm_write = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_WAIT_LEN, S_RECV: rx_ready = 1'b1;
            S_WRITE:            pm_write = 1'b1;
            S_RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR:              err = 1'b1;
            default: ;
        endcase
    end

    // Header capture, word assembly, address/word counting and inter-byte timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            pm_addr    <= '0;
            pm_wdata   <= '0;
        end else begin
            case (state_q)
                S_WAIT_LEN: begin
                    if (xfer) begin
                        len_q      <= (rx_data == 8'd0) ? WCNT_W'(256) : WCNT_W'(rx_data);
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        tmo_q      <= '0;
                        pm_addr    <= '0;
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        pm_wdata   <= {pm_wdata[23:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        tmo_q      <= '0;
                    end else if (tmo_hit) begin
                        byte_cnt_q <= '0;
                        word_cnt_q <= '0;
                    end else if (tmo_en) begin
                        tmo_q <= tmo_q + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    word_cnt_q <= word_cnt_q + WCNT_W'(1);
                    pm_addr    <= pm_addr + 8'd1;
                    tmo_q      <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized images
// checked against a word-level model of the expected program-memory writes.
module tb_prog_loader;

    localparam int unsigned T  = 8;
    localparam int unsigned CW = 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        load_req = 1'b0;
    logic        rx_ready;
    logic        pm_write;
    logic [7:0]  pm_addr;
    logic [31:0] pm_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    prog_loader #(.TIMEOUT_CYC(T), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .load_req (load_req),
        .pm_write (pm_write),
        .pm_addr  (pm_addr),
        .pm_wdata (pm_wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  img[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Capture every program-memory write; the core must be held and input stalled meanwhile
    always @(negedge clk) begin
        if (pm_write === 1'b1) begin
            wa_q.push_back(pm_addr);
            wd_q.push_back(pm_wdata);
            check("wr_rx_ready", 32'(rx_ready), 32'd0);
            check("wr_cpu_rst", 32'(cpu_rst), 32'd1);
            check("wr_done", 32'(done), 32'd0);
        end
    end

    task automatic fill_img(input int nbytes);
        img.delete();
        for (int i = 0; i < nbytes; i++) img.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                waits++;
            end
        end
        check("send_accept", 32'(ok), 32'd1);
    endtask

    // Sends header + img, then checks release timing and the full write list
    task automatic run_image(input logic [7:0] hdr, input int gap_max);
        int          n;
        int          w;
        int          gap;
        logic [31:0] exp_w;
        n = (hdr == 8'd0) ? 256 : int'(hdr);
        wa_q.delete();
        wd_q.delete();
        send_byte(hdr, 0, w);
        for (int k = 0; k < 4 * n; k++) begin
            gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
            send_byte(img[k], gap, w);
            if (gap_max == 0) check("stall_cycles", 32'(w), (k > 0 && k % 4 == 0) ? 32'd1 : 32'd0);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        check("last_wr", 32'(pm_write), 32'd1);
        check("last_addr", 32'(pm_addr), 32'(n - 1));
        check("pre_release_cpu_rst", 32'(cpu_rst), 32'd1);
        check("pre_release_done", 32'(done), 32'd0);
        @(negedge clk);
        check("run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("run_done", 32'(done), 32'd1);
        check("run_rx_ready", 32'(rx_ready), 32'd0);
        check("wr_count", 32'(wa_q.size()), 32'(n));
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            exp_w = {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
            check("wr_addr", 32'(wa_q[i]), 32'(i));
            check("wr_data", wd_q[i], exp_w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        @(negedge clk);
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check("reload_err", 32'(err), 32'd0);
        check("reload_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int n;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_pm_write", 32'(pm_write), 32'd0);
        check("rst_pm_addr", 32'(pm_addr), 32'd0);
        check("rst_pm_wdata", pm_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        rst = 1'b1;

        // Two-word directed image with rx_valid held high
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_image(8'h02, 0);
        check("dir_word0", wd_q[0], 32'h12345678);
        check("dir_word1", wd_q[1], 32'h9ABCDEF0);
        repeat (3) @(negedge clk);
        check("run_hold_done", 32'(done), 32'd1);
        check("run_hold_nowrite", 32'(wa_q.size()), 32'd2);
        @(posedge clk);
        #1;

        // Reload from RUN and random images with idle gaps
        pulse_reload();
        fill_img(12);
        run_image(8'd3, 3);
        for (int r = 0; r < 3; r++) begin
            pulse_reload();
            n = int'($urandom_range(6, 1));
            fill_img(4 * n);
            run_image(8'(n), 3);
        end

        // 256-word image (header 0)
        pulse_reload();
        fill_img(1024);
        run_image(8'h00, 0);

        // Inter-byte timeout
        pulse_reload();
        wa_q.delete();
        send_byte(8'h01, 0, w);
        send_byte(8'hAA, 0, w);
        send_byte(8'hBB, 0, w);
        rx_valid = 1'b0;
        repeat (T + 1) @(negedge clk);
        check("tmo_not_yet", 32'(err), 32'd0);
        @(negedge clk);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_cpu_rst", 32'(cpu_rst), 32'd1);
        check("tmo_rx_ready", 32'(rx_ready), 32'd0);
        check("tmo_done", 32'(done), 32'd0);
        check("tmo_no_write", 32'(wa_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("err_rx_ready", 32'(rx_ready), 32'd0);
        check("err_held", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;

        // Recovery from ERR
        pulse_reload();
        img = '{8'h00, 8'h00, 8'h00, 8'h01};
        run_image(8'h01, 0);
        check("recover_word", wd_q[0], 32'h00000001);

        // Asynchronous reset mid-load
        pulse_reload();
        fill_img(12);
        send_byte(8'h03, 0, w);
        for (int k = 0; k < 6; k++) send_byte(img[k], 0, w);
        check("pre_rst_addr", 32'(pm_addr), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_pm_write", 32'(pm_write), 32'd0);
        check("arst_pm_addr", 32'(pm_addr), 32'd0);
        check("arst_pm_wdata", pm_wdata, 32'd0);
        check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        fill_img(4);
        run_image(8'h01, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1);
    end

endmodule
